vec_mem_sequencer: RTL

Sequences VLD/VST vector transfers between the 16-bit data memory and the vector register file. One vector is 16 elements of 16 bits (256 bits), moved as 16 consecutive memory words. The instruction decoder issues a start pulse, then waits on busy/done. The block owns the memory port and the VRF write port for the duration of the transfer.

---
 rtl/vec_mem_sequencer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/vec_mem_sequencer.sv
// Moves one 16-element vector between the 16-bit data memory and the vector
// register file: VLD gathers 16 words into a VRF write, VST scatters a VRF entry.
module vec_mem_sequencer #(
  parameter int N_ELEM = 16,
  parameter int DW     = 16,
  parameter int AW     = 16,
  parameter int RW     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 is_store,
  input  logic [AW-1:0]        base_addr,
  input  logic [RW-1:0]        vreg,
  output logic [RW-1:0]        vrf_rd_addr,
  input  logic [N_ELEM*DW-1:0] vrf_rd_data,
  output logic [RW-1:0]        vrf_wr_dst,
  output logic [N_ELEM*DW-1:0] vrf_wr_data,
  output logic                 vrf_wr_en,
  output logic [AW-1:0]        mem_addr,
  output logic                 mem_rd,
  output logic                 mem_wr,
  output logic [DW-1:0]        mem_wdata,
  input  logic [DW-1:0]        mem_rdata,
  output logic                 busy,
  output logic                 done,
  output logic [2:0]           fsm_state
);

  // Handshake: start is a one-cycle request honoured only while busy=0; operands
  // are sampled on that edge and done pulses once when the transfer has finished.
  localparam int CW = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;
  localparam int VW = N_ELEM * DW;
  localparam logic [CW-1:0] LAST = CW'(N_ELEM - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_ISSUE = 3'd1,
    LD_DRAIN = 3'd2,
    LD_WB    = 3'd3,
    ST_ISSUE = 3'd4,
    FIN      = 3'd5
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [AW-1:0]   base_q;
  logic [RW-1:0]   vreg_q;
  logic [VW-1:0]   vbuf;
  logic [VW-1:0]   wb_hold;
  logic            cap_pending;
  logic [CW-1:0]   cap_idx;

  assign fsm_state = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Read data trails the strobe by one cycle, so the element index travels with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt         <= '0;
      base_q      <= '0;
      vreg_q      <= '0;
      vbuf        <= '0;
      wb_hold     <= '0;
      cap_pending <= 1'b0;
      cap_idx     <= '0;
    end else begin
      cap_pending <= (state == LD_ISSUE);
      cap_idx     <= cnt;
      if (cap_pending) vbuf[DW*cap_idx +: DW] <= mem_rdata;
      case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            vreg_q <= vreg;
            cnt    <= '0;
            if (is_store) vbuf <= vrf_rd_data;
          end
        end
        LD_ISSUE, ST_ISSUE: begin
          if (cnt == LAST) cnt <= '0;
          else             cnt <= cnt + 1'b1;
        end
        LD_WB:   wb_hold <= vbuf;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx    = state;
    busy        = (state != IDLE);
    done        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    vrf_wr_en   = 1'b0;
    vrf_wr_dst  = '0;
    vrf_wr_data = wb_hold;
    vrf_rd_addr = vreg_q;
    case (state)
      IDLE: begin
        // Pass-through so a store can grab its source vector on the start edge.
        vrf_rd_addr = rst ? vreg : '0;
        if (start) state_nx = is_store ? ST_ISSUE : LD_ISSUE;
      end
      LD_ISSUE: begin
        mem_rd   = 1'b1;
        mem_addr = base_q + AW'(cnt);
        if (cnt == LAST) state_nx = LD_DRAIN;
      end
      LD_DRAIN: state_nx = LD_WB;
      LD_WB: begin
        vrf_wr_en   = 1'b1;
        vrf_wr_dst  = vreg_q;
        vrf_wr_data = vbuf;
        done        = 1'b1;
        state_nx    = IDLE;
      end
      ST_ISSUE: begin
        mem_wr    = 1'b1;
        mem_addr  = base_q + AW'(cnt);
        mem_wdata = vbuf[DW*cnt +: DW];
        if (cnt == LAST) state_nx = FIN;
      end
      FIN: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule
